// File: rtl/music_note_sender.sv
// rtl/music_note_sender.sv - queues note events and sends each as a 3-byte ASCII line to a UART transmitter
module music_note_sender #(
    parameter logic [7:0] PREFIX  = 8'h4C,
    parameter int         FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_valid,
    input  logic [3:0] note_id,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [3:0]         cur_id_q, cur_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         mem_q [DEPTH];
    logic [3:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    logic       full, empty, push, pop;
    logic [7:0] digit, frame_byte;

    // A pop frees a slot in the same cycle, so a note arriving exactly then is still accepted.
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        pop   = (state_q == IDLE) && !empty && tx_ready;
        push  = note_valid && (!full || pop);
    end

    always_comb begin
        digit = (cur_id_q < 4'd10) ? (8'h30 + {4'h0, cur_id_q}) : (8'h37 + {4'h0, cur_id_q});
        case (byte_idx_q)
            2'd0:    frame_byte = PREFIX;
            2'd1:    frame_byte = digit;
            default: frame_byte = 8'h0A;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (note_valid & full & ~pop);
        if (push) begin
            mem_d[wr_ptr_q] = note_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        cur_id_d   = cur_id_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_id_d   = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tx_data_d  = frame_byte;
                tx_start_d = 1'b1;
                state_d    = START;
            end
            START: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!tx_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (byte_idx_q == 2'd2) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            cur_id_q   <= 4'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            cur_id_q   <= cur_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_music_note_sender.sv
// tb/tb_music_note_sender.sv - scoreboard bench for music_note_sender with a simple UART transmitter model
module tb_music_note_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       note_valid = 1'b0;
    logic [3:0] note_id = 4'd0;
    logic       tx_ready = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overflow;

    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   pulse_cnt = 0;
    int   reset_gen = 0;
    bit   uart_en = 1'b1;
    logic [7:0] exp_q [$];

    music_note_sender dut (
        .clk        (clk),
        .rst        (rst),
        .note_valid (note_valid),
        .note_id    (note_id),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // Transmitter model and output monitor: every tx_start is matched against the scoreboard.
    initial begin
        logic [7:0] cap;
        logic [7:0] exp_b;
        int         gen;
        forever begin
            @(negedge clk);
            if (rst && tx_start) begin
                pulse_cnt++;
                chk_cnt++;
                if (tx_ready !== 1'b1) $display("FAIL start_while_not_ready: tx_ready=%b required 1", tx_ready);
                else pass_cnt++;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: got %h with empty scoreboard", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) $display("FAIL tx_byte: got %h required %h", tx_data, exp_b);
                    else pass_cnt++;
                end
                if (uart_en) begin
                    cap = tx_data;
                    gen = reset_gen;
                    @(posedge clk);
                    #1 tx_ready = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    if (gen == reset_gen && rst) begin
                        chk_cnt++;
                        if (tx_data !== cap) $display("FAIL tx_data_hold: got %h required %h", tx_data, cap);
                        else pass_cnt++;
                    end
                    tx_ready = 1'b1;
                end
            end
        end
    end

    task automatic push_frame(input logic [3:0] id);
        logic [7:0] d;
        d = (id < 4'd10) ? (8'h30 + {4'h0, id}) : (8'h41 + {4'h0, id} - 8'd10);
        exp_q.push_back(8'h4C);
        exp_q.push_back(d);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_note(input logic [3:0] id);
        @(negedge clk);
        note_valid = 1'b1;
        note_id    = id;
        @(negedge clk);
        note_valid = 1'b0;
        note_id    = 4'hF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        reset_gen++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n >= 3000) $display("FAIL %s_drain_timeout: busy=%b pending=%0d required 0/0", name, busy, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        bit seen;
        seen = 1'b0;
        rst = 1'b0;
        reset_gen++;
        #1;
        chk_cnt++;
        if ({tx_start, tx_data, busy, overflow} !== 11'h000)
            $display("FAIL reset_outputs: start=%b data=%h busy=%b ovf=%b required 0/00/0/0", tx_start, tx_data, busy, overflow);
        else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if (tx_start !== 1'b0) seen = 1'b1;
        end
        chk_cnt++;
        if (seen) $display("FAIL reset_hold_pulse: tx_start seen=1 required 0");
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_note();
        int base, n;
        base = pulse_cnt;
        push_frame(4'd3);
        note_valid = 1'b1;
        note_id    = 4'd3;
        @(negedge clk);
        note_valid = 1'b0;
        chk_cnt++;
        if (tx_start !== 1'b0) $display("FAIL latency_c1: tx_start=%b required 0", tx_start); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (tx_start !== 1'b0) $display("FAIL latency_c2: tx_start=%b required 0", tx_start); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (tx_start !== 1'b1) $display("FAIL latency_c3: tx_start=%b required 1", tx_start); else pass_cnt++;
        n = 0;
        while (pulse_cnt < base + 3 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (tx_ready !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_before_last_rise: busy=%b required 1", busy); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_after_last_rise: busy=%b required 0", busy); else pass_cnt++;
        chk_cnt++;
        if (pulse_cnt - base != 3) $display("FAIL single_pulse_count: got %0d required 3", pulse_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_digits();
        logic [3:0] ids [3];
        ids[0] = 4'd12;
        ids[1] = 4'd9;
        ids[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            push_frame(ids[i]);
            send_note(ids[i]);
            wait_idle("digits");
        end
    endtask

    task automatic test_overflow_burst();
        int base;
        base = pulse_cnt;
        chk_cnt++;
        if (overflow !== 1'b0) $display("FAIL overflow_pre_burst: got %b required 0", overflow); else pass_cnt++;
        for (int i = 0; i < 5; i++) push_frame(4'(i));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            note_valid = 1'b1;
            note_id    = 4'(i);
            @(negedge clk);
        end
        note_valid = 1'b0;
        chk_cnt++;
        if (overflow !== 1'b1) $display("FAIL overflow_after_burst: got %b required 1", overflow); else pass_cnt++;
        wait_idle("burst");
        chk_cnt++;
        if (pulse_cnt - base != 15) $display("FAIL burst_pulse_count: got %0d required 15", pulse_cnt - base);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b required 1", overflow); else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        do_reset();
        uart_en  = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_frame(4'(10 + i));
            send_note(4'(10 + i));
        end
        push_frame(4'd14);
        @(negedge clk);
        note_valid = 1'b1;
        note_id    = 4'd14;
        tx_ready   = 1'b1;
        uart_en    = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (dut.count_q !== 3'd4) $display("FAIL push_pop_count: got %0d required 4", dut.count_q); else pass_cnt++;
        chk_cnt++;
        if (overflow !== 1'b0) $display("FAIL push_pop_overflow: got %b required 0", overflow); else pass_cnt++;
        @(negedge clk);
        note_valid = 1'b0;
        wait_idle("push_pop");
        chk_cnt++;
        if (overflow !== 1'b0) $display("FAIL push_pop_overflow_end: got %b required 0", overflow); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int base, n;
        base = pulse_cnt;
        push_frame(4'd7);
        send_note(4'd7);
        n = 0;
        while (pulse_cnt < base + 2 && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_gen++;
        #1;
        chk_cnt++;
        if ({tx_start, tx_data, busy, overflow} !== 11'h000)
            $display("FAIL mid_reset_outputs: start=%b data=%h busy=%b ovf=%b required 0/00/0/0", tx_start, tx_data, busy, overflow);
        else pass_cnt++;
        exp_q.delete();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = pulse_cnt;
        push_frame(4'd1);
        send_note(4'd1);
        wait_idle("after_reset");
        chk_cnt++;
        if (pulse_cnt - base != 3) $display("FAIL after_reset_pulse_count: got %0d required 3", pulse_cnt - base);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_digits();
        test_overflow_burst();
        test_push_pop_full();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
